record_serializer: RTL and testbench
====================================

Name: record_serializer

Overview:
Reader-side counterpart of the byte-assembling record FIFO. It requests one full record from the FIFO's record port, latches it, and emits it one byte at a time on a valid/ready byte stream, LSB byte first. It sits between the record FIFO and byte-oriented consumers such as the step/motion output stages or a loopback/debug UART. It also keeps a count of records sent.

Parameters:
RECORD_SIZE_BYTES, 16, bytes per record; must be >= 2.
IDX_W, $clog2(RECORD_SIZE_BYTES+1), width of the internal byte index.
COUNT_W, 16, width of the rec_count statistics counter.

Ports:
clk  in  1  single system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-low reset.
rec_available  in  1  FIFO holds at least one record.
rec_request  out  1  level request for a record; held until rec_ready.
rec_ready  in  1  rec_data is valid this cycle; one-cycle strobe from the FIFO.
rec_data  in  RECORD_SIZE_BYTES*8  record payload; byte k is rec_data[8k+7:8k].
out_byte  out  8  current output byte.
out_valid  out  1  out_byte is valid.
out_ready  in  1  consumer accepts out_byte this cycle.
out_last  out  1  qualifies the final byte of the record frame.
busy  out  1  high whenever state != IDLE.
rec_count  out  COUNT_W  number of frames completed; wraps modulo 2^COUNT_W.

Behaviour:
- Reset (rst=0, asynchronous) drives the following to zero: rec_request, out_valid, out_last, out_byte, busy, rec_count, the byte index and the shift register. State goes to IDLE. A partially sent record is discarded and is not re-requested.
- All outputs are registered.
- State IDLE:
  - If rec_available=1, go to REQ. rec_request rises in the next cycle.
  - rec_ready arriving in IDLE is ignored.
- State REQ:
  - rec_request=1.
  - When rec_ready=1: latch rec_data into the shift register, set index=0, drop rec_request, and go to SEND.
  - out_valid=1 with out_byte=rec_data[7:0] in the cycle after rec_ready (one-cycle latency).
  - rec_available dropping while in REQ does not cancel the request; the block waits for rec_ready.
- State SEND:
  - out_valid=1 throughout.
  - A transfer occurs when out_valid & out_ready. On a transfer, the shift register shifts right by 8 and the index increments.
  - out_byte is held stable while out_ready=0; there is no bubble between bytes under continuous out_ready.
  - out_last=1 exactly when index = RECORD_SIZE_BYTES-1.
  - On transfer of the last byte: rec_count increments, out_valid drops, and the state goes to IDLE.
- Throughput: one byte per cycle within a record. Minimum gap between records is 2 idle cycles (IDLE then REQ).
- rec_count wraps from 2^COUNT_W-1 to 0 with no saturation.
- Simultaneous rec_available=1 and the last-byte transfer: go to IDLE first, then REQ next cycle. No look-ahead request is made.
- rec_data is sampled only on rec_ready while in REQ. Later changes to rec_data do not affect the frame in flight.

Optional Feature:
RECORD_CHECKSUM_EN:
- Defined:
  - At latch time, compute csum = XOR of all RECORD_SIZE_BYTES bytes of rec_data and register it.
  - After the last record byte, enter state CSUM and emit csum as one extra byte with out_valid=1 and out_last=1.
  - out_last is then not asserted on the final record byte.
  - rec_count increments on the CSUM byte transfer.
  - Frame length becomes RECORD_SIZE_BYTES+1.
- Undefined: no CSUM state, no csum register, and frames are exactly RECORD_SIZE_BYTES bytes.

Decomposition:
- Shared package record_pkg holds:
  - RECORD_SIZE_BYTES default and BYTE_W=8;
  - the state enum ser_state_t {IDLE, REQ, SEND, CSUM};
  - a record_t typedef of logic [RECORD_SIZE_BYTES*8-1:0].
- One sub-module is natural: record_xor_reduce, a combinational byte-wise XOR tree. It is instantiated only under RECORD_CHECKSUM_EN.

Test Plan:
All scenarios use RECORD_SIZE_BYTES=4.
1. Basic frame: rec_available=1, rec_ready one cycle after rec_request with rec_data=0x44332211, out_ready=1.
   -> bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; out_last only on 0x44; rec_count=1; out_valid rises 1 cycle after rec_ready.
2. Backpressure: as in 1, with out_ready low for 3 cycles while 0x22 is presented.
   -> 0x22 held stable with out_valid=1; no byte lost or duplicated; same order as in 1.
3. Spurious strobe and request hold: pulse rec_ready while IDLE with data 0xDEADBEEF, then drop rec_available during REQ.
   -> the IDLE strobe is ignored; rec_request stays 1 until the real rec_ready; only the requested record is emitted.
4. Reset mid-frame: assert rst after byte 0x22 is transferred.
   -> all outputs 0 immediately (asynchronously); after release the block goes to IDLE; 0x33/0x44 are never emitted; rec_count=0.
5. Counter wrap: preload by sending 65536 frames (or use COUNT_W=4 and send 16 frames).
   -> rec_count returns to 0.
6. RECORD_CHECKSUM_EN with 0x44332211.
   -> 5 bytes: 0x11, 0x22, 0x33, 0x44, 0x44 (checksum); out_last only on the 5th byte; rec_count=1.

Source files
------------

// File: rtl/record_pkg.sv
// Shared types and constants for the record serializer.
package record_pkg;

  localparam int unsigned DEFAULT_RECORD_SIZE_BYTES = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND,
    CSUM
  } ser_state_t;

  typedef logic [DEFAULT_RECORD_SIZE_BYTES*BYTE_W-1:0] record_t;

endpackage

// File: rtl/record_xor_reduce.sv
// Combinational byte-wise XOR of a whole record, used as the frame checksum.
module record_xor_reduce
  import record_pkg::*;
#(
  parameter int unsigned NUM_BYTES = DEFAULT_RECORD_SIZE_BYTES
) (
  input  logic [NUM_BYTES*BYTE_W-1:0] data,
  output logic [BYTE_W-1:0]           csum
);

  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      csum = csum ^ data[i*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/record_serializer.sv
// Requests a record from the record FIFO and emits it LSB byte first on a valid/ready stream.
// Define RECORD_CHECKSUM_EN to append an XOR checksum byte to every frame.
module record_serializer
  import record_pkg::*;
#(
  parameter int unsigned RECORD_SIZE_BYTES = DEFAULT_RECORD_SIZE_BYTES,
  parameter int unsigned IDX_W             = $clog2(RECORD_SIZE_BYTES + 1),
  parameter int unsigned COUNT_W           = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rec_available,
  output logic                                rec_request,
  input  logic                                rec_ready,
  input  logic [RECORD_SIZE_BYTES*BYTE_W-1:0] rec_data,
  output logic [BYTE_W-1:0]                   out_byte,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic [COUNT_W-1:0]                  rec_count
);

  localparam int unsigned RecW = RECORD_SIZE_BYTES * BYTE_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(RECORD_SIZE_BYTES - 1);

  ser_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RecW-1:0]    shreg_q, shreg_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;

`ifdef RECORD_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d, csum_calc;

  record_xor_reduce #(
    .NUM_BYTES(RECORD_SIZE_BYTES)
  ) u_xor (
    .data(rec_data),
    .csum(csum_calc)
  );
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    count_d = count_q;
`ifdef RECORD_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rec_available) state_d = REQ;
      end
      REQ: begin
        if (rec_ready) begin
          shreg_d = rec_data;
          idx_d   = '0;
          state_d = SEND;
`ifdef RECORD_CHECKSUM_EN
          csum_d  = csum_calc;
`endif
        end
      end
      SEND: begin
        // out_valid is always high here, so out_ready alone marks a transfer.
        if (out_ready) begin
          shreg_d = shreg_q >> BYTE_W;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            idx_d = '0;
`ifdef RECORD_CHECKSUM_EN
            shreg_d = RecW'(csum_q);
            state_d = CSUM;
`else
            count_d = count_q + 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef RECORD_CHECKSUM_EN
      CSUM: begin
        if (out_ready) begin
          shreg_d = '0;
          count_d = count_q + 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    req_d   = (state_d == REQ);
    valid_d = (state_d == SEND) || (state_d == CSUM);
    busy_d  = (state_d != IDLE);
`ifdef RECORD_CHECKSUM_EN
    last_d  = (state_d == CSUM);
`else
    last_d  = (state_d == SEND) && (idx_d == LastIdx);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RECORD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) csum_q <= '0;
    else      csum_q <= csum_d;
  end
`endif

  assign rec_request = req_q;
  assign out_byte    = shreg_q[BYTE_W-1:0];
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign busy        = busy_q;
  assign rec_count   = count_q;

endmodule

// File: tb/tb_record_serializer.sv
// Directed bench for record_serializer with 4-byte records and a 4-bit frame counter.
// Also covers the RECORD_CHECKSUM_EN build when that macro is defined.
module tb_record_serializer;

  logic        clk;
  logic        rst;
  logic        rec_available;
  logic        rec_request;
  logic        rec_ready;
  logic [31:0] rec_data;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [3:0]  rec_count;

  int checks   = 0;
  int failures = 0;

  record_serializer #(
    .RECORD_SIZE_BYTES(4),
    .COUNT_W          (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rec_available(rec_available),
    .rec_request  (rec_request),
    .rec_ready    (rec_ready),
    .rec_data     (rec_data),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .rec_count    (rec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        avail;
    logic        rdy;
    logic [31:0] data;
    logic        ordy;
    logic        req;
    logic        valid;
    logic [7:0]  obyte;
    logic        last;
    logic        bsy;
    logic [3:0]  count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic avail, input logic rdy, input logic [31:0] data,
                              input logic ordy, input logic req, input logic valid,
                              input logic [7:0] obyte, input logic last, input logic bsy,
                              input logic [3:0] count);
    vec_t v;
    v = '{avail, rdy, data, ordy, req, valid, obyte, last, bsy, count};
    return v;
  endfunction

  function automatic void add(input logic avail, input logic rdy, input logic [31:0] data,
                              input logic ordy, input logic req, input logic valid,
                              input logic [7:0] obyte, input logic last, input logic bsy,
                              input logic [3:0] count);
    vecs.push_back(mk(avail, rdy, data, ordy, req, valid, obyte, last, bsy, count));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, then compare the registered outputs just after the edge.
  task automatic apply_vec(input string name, input int idx, input vec_t v);
    rec_available = v.avail;
    rec_ready     = v.rdy;
    rec_data      = v.data;
    out_ready     = v.ordy;
    @(posedge clk);
    #1;
    checks++;
    if (rec_request !== v.req || out_valid !== v.valid || (v.valid && out_byte !== v.obyte) ||
        out_last !== v.last || busy !== v.bsy || rec_count !== v.count) begin
      failures++;
      $display("FAIL %s[%0d]: got req=%b valid=%b byte=%h last=%b busy=%b count=%0d, want req=%b valid=%b byte=%h last=%b busy=%b count=%0d",
               name, idx, rec_request, out_valid, out_byte, out_last, busy, rec_count,
               v.req, v.valid, v.obyte, v.last, v.bsy, v.count);
    end
  endtask

  task automatic send_frame(input logic [31:0] d);
    int n;
    logic [7:0] cs;
    cs = d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    rec_available = 1'b1;
    rec_ready     = 1'b0;
    out_ready     = 1'b1;
    n = 0;
    while (!rec_request && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("frame_req_wait", 32'(rec_request), 32'd1);
    rec_available = 1'b0;
    rec_ready     = 1'b1;
    rec_data      = d;
    @(posedge clk);
    #1;
    rec_ready = 1'b0;
    rec_data  = ~d;
    for (int k = 0; k < 4; k++) begin
      chk("frame_valid", 32'(out_valid), 32'd1);
      chk("frame_byte", 32'(out_byte), 32'(d[8*k +: 8]));
`ifdef RECORD_CHECKSUM_EN
      chk("frame_last", 32'(out_last), 32'd0);
`else
      chk("frame_last", 32'(out_last), 32'(k == 3));
`endif
      @(posedge clk);
      #1;
    end
`ifdef RECORD_CHECKSUM_EN
    chk("frame_csum", 32'(out_byte), 32'(cs));
    chk("frame_csum_last", 32'(out_last), 32'd1);
    @(posedge clk);
    #1;
`endif
    chk("frame_end_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    rec_available = 1'b0;
    rec_ready = 1'b0;
    rec_data = '0;
    out_ready = 1'b0;

    // Basic frame
    add(1, 0, 32'h0,         1, 1, 0, 8'h00, 0, 1, 0);
    add(1, 1, 32'h44332211,  1, 0, 1, 8'h11, 0, 1, 0);
    add(0, 0, 32'hFFFFFFFF,  1, 0, 1, 8'h22, 0, 1, 0);
    add(0, 0, 32'hFFFFFFFF,  1, 0, 1, 8'h33, 0, 1, 0);
`ifdef RECORD_CHECKSUM_EN
    add(0, 0, 32'hFFFFFFFF,  1, 0, 1, 8'h44, 0, 1, 0);
`endif
    add(0, 0, 32'hFFFFFFFF,  1, 0, 1, 8'h44, 1, 1, 0);
    add(0, 0, 32'h0,         1, 0, 0, 8'h00, 0, 0, 1);
    // Backpressure on the second byte
    add(1, 0, 32'h0,         1, 1, 0, 8'h00, 0, 1, 1);
    add(0, 1, 32'h44332211,  1, 0, 1, 8'h11, 0, 1, 1);
    add(0, 0, 32'h0,         1, 0, 1, 8'h22, 0, 1, 1);
    add(0, 0, 32'h0,         0, 0, 1, 8'h22, 0, 1, 1);
    add(0, 0, 32'h0,         0, 0, 1, 8'h22, 0, 1, 1);
    add(0, 0, 32'h0,         0, 0, 1, 8'h22, 0, 1, 1);
    add(0, 0, 32'h0,         1, 0, 1, 8'h33, 0, 1, 1);
`ifdef RECORD_CHECKSUM_EN
    add(0, 0, 32'h0,         1, 0, 1, 8'h44, 0, 1, 1);
`endif
    add(0, 0, 32'h0,         1, 0, 1, 8'h44, 1, 1, 1);
    add(0, 0, 32'h0,         1, 0, 0, 8'h00, 0, 0, 2);
    // Spurious strobe in IDLE, then rec_available drops during REQ
    add(0, 1, 32'hDEADBEEF,  1, 0, 0, 8'h00, 0, 0, 2);
    add(1, 0, 32'h0,         1, 1, 0, 8'h00, 0, 1, 2);
    add(0, 0, 32'h0,         1, 1, 0, 8'h00, 0, 1, 2);
    add(0, 0, 32'h0,         1, 1, 0, 8'h00, 0, 1, 2);
    add(0, 1, 32'h8899AABB,  1, 0, 1, 8'hBB, 0, 1, 2);
    add(0, 0, 32'h0,         1, 0, 1, 8'hAA, 0, 1, 2);
    add(0, 0, 32'h0,         1, 0, 1, 8'h99, 0, 1, 2);
`ifdef RECORD_CHECKSUM_EN
    add(0, 0, 32'h0,         1, 0, 1, 8'h88, 0, 1, 2);
    add(0, 0, 32'h0,         1, 0, 1, 8'h00, 1, 1, 2);
`else
    add(0, 0, 32'h0,         1, 0, 1, 8'h88, 1, 1, 2);
`endif
    // rec_available high during the final transfer: IDLE first, REQ after
    add(1, 0, 32'h0,         1, 0, 0, 8'h00, 0, 0, 3);
    add(1, 0, 32'h0,         1, 1, 0, 8'h00, 0, 1, 3);
    add(0, 1, 32'h0D0C0B0A,  1, 0, 1, 8'h0A, 0, 1, 3);
    add(0, 0, 32'h0,         1, 0, 1, 8'h0B, 0, 1, 3);
    add(0, 0, 32'h0,         1, 0, 1, 8'h0C, 0, 1, 3);

    #12;
    chk("reset_req",   32'(rec_request), 32'd0);
    chk("reset_valid", 32'(out_valid),   32'd0);
    chk("reset_byte",  32'(out_byte),    32'd0);
    chk("reset_last",  32'(out_last),    32'd0);
    chk("reset_busy",  32'(busy),        32'd0);
    chk("reset_count", 32'(rec_count),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (vecs[i]) apply_vec("vec", i, vecs[i]);

    // Asynchronous reset mid-frame, between clock edges
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_req",   32'(rec_request), 32'd0);
    chk("midreset_valid", 32'(out_valid),   32'd0);
    chk("midreset_byte",  32'(out_byte),    32'd0);
    chk("midreset_last",  32'(out_last),    32'd0);
    chk("midreset_busy",  32'(busy),        32'd0);
    chk("midreset_count", 32'(rec_count),   32'd0);
    rec_available = 1'b0;
    rec_ready     = 1'b0;
    out_ready     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_vec("post_reset", i, mk(0, 0, 32'h0, 1, 0, 0, 8'h00, 0, 0, 0));
    end

    // Counter wrap with a 4-bit counter
    for (int f = 0; f < 15; f++) begin
      send_frame(32'h01020304 * (f + 1));
    end
    chk("count_before_wrap", 32'(rec_count), 32'd15);
    send_frame(32'hA5C30F96);
    chk("count_wrap", 32'(rec_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
